// File: rtl/tx_pkg.sv
// Shared constants, state encoding and RATE -> N_DBPS lookup for the 802.11a TX frame sequencer.
// Pure definitions with no logic and no latency; none of the contents take part in flow control.
package tx_pkg;

    localparam int          LEN_WIDTH      = 12;
    localparam int          PREAMBLE_BITS  = 96;
    localparam logic [6:0]  SCRAMBLER_SEED = 7'b1011101;
    localparam logic [7:0]  PREAMBLE_BYTE  = 8'hAA;

    localparam int SIGNAL_BITS  = 24;
    localparam int SERVICE_BITS = 16;
    localparam int TAIL_BITS    = 6;

    localparam logic [3:0] RATE_6M  = 4'b1101;
    localparam logic [3:0] RATE_9M  = 4'b1111;
    localparam logic [3:0] RATE_12M = 4'b0101;
    localparam logic [3:0] RATE_18M = 4'b0111;
    localparam logic [3:0] RATE_24M = 4'b1001;
    localparam logic [3:0] RATE_36M = 4'b1011;
    localparam logic [3:0] RATE_48M = 4'b0001;
    localparam logic [3:0] RATE_54M = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SIGNAL,
        ST_SERVICE,
        ST_DATA,
        ST_TAIL,
        ST_PAD
    } state_t;

    // Returns 0 for codes that are not legal 802.11a rates.
    function automatic logic [7:0] ndbps(input logic [3:0] rate);
        case (rate)
            RATE_6M:  ndbps = 8'd24;
            RATE_9M:  ndbps = 8'd36;
            RATE_12M: ndbps = 8'd48;
            RATE_18M: ndbps = 8'd72;
            RATE_24M: ndbps = 8'd96;
            RATE_36M: ndbps = 8'd144;
            RATE_48M: ndbps = 8'd192;
            RATE_54M: ndbps = 8'd216;
            default:  ndbps = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/tx_signal_field.sv
// Combinational SIGNAL field builder; bit 0 of the vector is the first bit on air.
// Zero latency; no handshake, the vector just follows the latched rate and length.
module tx_signal_field
    import tx_pkg::*;
(
    input  logic [3:0]           rate,
    input  logic [LEN_WIDTH-1:0] length,
    output logic [23:0]          signal_vec
);

    logic parity;

    assign parity     = ^{rate, length};
    assign signal_vec = {6'b000000, parity, length, 1'b0, rate[0], rate[1], rate[2], rate[3]};

endmodule

// File: rtl/tx_frame_sequencer.sv
// Serialises one 802.11a PPDU (preamble, SIGNAL, SERVICE, PSDU, tail, pad); first bit 1 cycle after Start.
// Bits move on BitValid&BitReady and hold while BitReady is low; DATA underruns drop BitValid until a byte arrives.
module tx_frame_sequencer
    import tx_pkg::*;
(
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [3:0]           Rate,
    input  logic [LEN_WIDTH-1:0] Length,
    input  logic [7:0]           DataByte,
    input  logic                 DataValid,
    output logic                 DataReady,
    output logic                 BitOut,
    output logic                 BitValid,
    input  logic                 BitReady,
    output logic                 ScrambleEn,
    output logic                 SeedLoad,
    output logic [6:0]           SeedValue,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Error
);

    state_t               state, state_nxt;
    logic [3:0]           rate_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [7:0]           pre_cnt;
    logic [4:0]           fld_cnt;
    logic [LEN_WIDTH+2:0] data_cnt;
    logic [7:0]           sym_cnt;
    logic [7:0]           buf_dat;
    logic                 buf_full;
    logic                 done_q;
    logic                 error_q;

    logic [23:0]          sig_vec;
    logic [7:0]           ndbps_q;
    logic [LEN_WIDTH+2:0] data_bits;
    logic [7:0]           cur_byte;
    logic [7:0]           sym_nxt;
    logic                 start_ok;
    logic                 rate_ok;
    logic                 xfer;
    logic                 field_last;
    logic                 last_bit;
    logic                 bit_out, bit_vld, scr_en, seed_ld, data_rdy;

    tx_signal_field u_signal_field (
        .rate       (rate_q),
        .length     (len_q),
        .signal_vec (sig_vec)
    );

    assign ndbps_q   = ndbps(rate_q);
    assign rate_ok   = (ndbps(Rate) != 8'd0);
    assign start_ok  = (state == ST_IDLE) && Start && !done_q;
    assign data_bits = {len_q, 3'b000};
    // An empty buffer passes DataByte straight through so byte boundaries cost no bubble.
    assign cur_byte  = buf_full ? buf_dat : DataByte;
    assign xfer      = bit_vld && BitReady;
    assign sym_nxt   = (sym_cnt == ndbps_q - 8'd1) ? 8'd0 : sym_cnt + 8'd1;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        bit_out    = 1'b0;
        bit_vld    = 1'b0;
        scr_en     = 1'b0;
        seed_ld    = 1'b0;
        data_rdy   = 1'b0;
        last_bit   = 1'b0;
        field_last = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok && rate_ok) begin
                    state_nxt = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                bit_vld = 1'b1;
                bit_out = PREAMBLE_BYTE[3'd7 - pre_cnt[2:0]];
                if (xfer && pre_cnt == 8'(PREAMBLE_BITS - 1)) begin
                    state_nxt = ST_SIGNAL;
                end
            end
            ST_SIGNAL: begin
                bit_vld    = 1'b1;
                bit_out    = sig_vec[fld_cnt];
                field_last = (fld_cnt == 5'(SIGNAL_BITS - 1));
                if (xfer && field_last) begin
                    seed_ld   = 1'b1;
                    state_nxt = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                bit_vld    = 1'b1;
                scr_en     = 1'b1;
                field_last = (fld_cnt == 5'(SERVICE_BITS - 1));
                if (xfer && field_last) begin
                    state_nxt = (len_q == '0) ? ST_TAIL : ST_DATA;
                end
            end
            ST_DATA: begin
                scr_en   = 1'b1;
                data_rdy = !buf_full && (data_cnt < data_bits);
                bit_vld  = buf_full || DataValid;
                bit_out  = cur_byte[data_cnt[2:0]];
                if (xfer && data_cnt == data_bits - 1'b1) begin
                    state_nxt = ST_TAIL;
                end
            end
            ST_TAIL: begin
                bit_vld    = 1'b1;
                field_last = (fld_cnt == 5'(TAIL_BITS - 1));
                if (xfer && field_last) begin
                    if (sym_nxt == 8'd0) begin
                        last_bit  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                bit_vld = 1'b1;
                scr_en  = 1'b1;
                if (xfer && sym_nxt == 8'd0) begin
                    last_bit  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rate_q   <= '0;
            len_q    <= '0;
            pre_cnt  <= '0;
            fld_cnt  <= '0;
            data_cnt <= '0;
            sym_cnt  <= '0;
            buf_dat  <= '0;
            buf_full <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            done_q  <= last_bit;
            error_q <= start_ok && !rate_ok;
            if (start_ok) begin
                rate_q <= Rate;
                len_q  <= Length;
            end
            if (state == ST_IDLE) begin
                pre_cnt  <= '0;
                fld_cnt  <= '0;
                data_cnt <= '0;
                sym_cnt  <= '0;
                buf_full <= 1'b0;
            end else if (xfer) begin
                case (state)
                    ST_PREAMBLE: pre_cnt <= pre_cnt + 8'd1;
                    ST_SIGNAL:   fld_cnt <= field_last ? 5'd0 : fld_cnt + 5'd1;
                    ST_SERVICE: begin
                        fld_cnt <= field_last ? 5'd0 : fld_cnt + 5'd1;
                        sym_cnt <= sym_nxt;
                    end
                    ST_DATA: begin
                        data_cnt <= data_cnt + 1'b1;
                        sym_cnt  <= sym_nxt;
                        if (data_cnt[2:0] == 3'd7) begin
                            buf_full <= 1'b0;
                        end
                    end
                    ST_TAIL: begin
                        fld_cnt <= field_last ? 5'd0 : fld_cnt + 5'd1;
                        sym_cnt <= sym_nxt;
                    end
                    ST_PAD:  sym_cnt <= sym_nxt;
                    default: ;
                endcase
            end
            // Only reachable with the buffer empty, so it never races the clear above.
            if (data_rdy && DataValid) begin
                buf_dat  <= DataByte;
                buf_full <= 1'b1;
            end
        end
    end

    assign DataReady  = data_rdy;
    assign BitOut     = bit_out;
    assign BitValid   = bit_vld;
    assign ScrambleEn = scr_en;
    assign SeedLoad   = seed_ld;
    assign SeedValue  = SCRAMBLER_SEED;
    assign Busy       = (state != ST_IDLE);
    assign Done       = done_q;
    assign Error      = error_q;

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Directed bench for tx_frame_sequencer: whole frames compared bit-for-bit against hand-built sequences.
module tb_tx_frame_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic [3:0]  Rate;
    logic [11:0] Length;
    logic [7:0]  DataByte;
    logic        DataValid;
    logic        BitReady;
    logic        DataReady, BitOut, BitValid, ScrambleEn, SeedLoad, Busy, Done, Error;
    logic [6:0]  SeedValue;

    tx_frame_sequencer dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .Rate       (Rate),
        .Length     (Length),
        .DataByte   (DataByte),
        .DataValid  (DataValid),
        .DataReady  (DataReady),
        .BitOut     (BitOut),
        .BitValid   (BitValid),
        .BitReady   (BitReady),
        .ScrambleEn (ScrambleEn),
        .SeedLoad   (SeedLoad),
        .SeedValue  (SeedValue),
        .Busy       (Busy),
        .Done       (Done),
        .Error      (Error)
    );

    always #5 Clock = ~Clock;

    int   tests = 0;
    int   fails = 0;
    logic got_q[$];
    logic exp_q[$];
    int   done_idx, seed_idx, scr_cnt;
    bit   saw_rdy, stall_ok, starve_ok;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic add(input int n, input logic v);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    task automatic add_seq(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i] == "1");
    endtask

    task automatic add_preamble();
        for (int i = 0; i < 48; i++) add_seq("10");
    endtask

    task automatic exp_len1_ff();
        exp_q.delete();
        add_preamble();
        add_seq("110101"); add(11, 1'b0); add(1, 1'b0); add(6, 1'b0);
        add(16, 1'b0); add(8, 1'b1); add(6, 1'b0); add(18, 1'b0);
    endtask

    task automatic cmp(input string tag);
        int first = -1;
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i] && first < 0) first = i;
        check({tag, "_first_bad_bit"}, first, -1);
    endtask

    task automatic run_frame(input logic [3:0] r, input logic [11:0] len, input logic [7:0] dbyte,
                             input int stall_at, input int starve_at, input int abort_at);
        int   xfers = 0;
        int   stall_left = 0;
        int   starve_left = 0;
        bit   stalled = 0, starved = 0, aborted = 0;
        logic hold_b = 1'b0, hold_v = 1'b0;
        got_q.delete();
        done_idx = -1; seed_idx = -1; scr_cnt = 0;
        saw_rdy = 0; stall_ok = 1; starve_ok = 1;
        @(negedge Clock);
        Rate = r; Length = len; DataByte = dbyte; DataValid = 1'b1; BitReady = 1'b1; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (abort_at >= 0 && xfers == abort_at) begin
                aborted = 1;
                break;
            end
            if (stall_at >= 0 && !stalled && xfers == stall_at) begin
                stalled = 1; stall_left = 5;
            end
            if (starve_at >= 0 && !starved && xfers == starve_at) begin
                starved = 1; starve_left = 10;
            end
            BitReady  = (stall_left == 0);
            DataValid = (starve_left == 0);
            #1;
            if (cyc == 0) begin
                check("start_busy", Busy, 1);
                check("start_valid", BitValid, 1);
                check("start_bit0", BitOut, 1);
            end
            if (Done) begin
                done_idx = xfers;
                break;
            end
            if (stall_left > 0) begin
                if (stall_left == 5) begin
                    hold_b = BitOut; hold_v = BitValid;
                end else if (BitOut !== hold_b || BitValid !== hold_v) begin
                    stall_ok = 0;
                end
                if (!BitValid) stall_ok = 0;
                stall_left--;
            end
            if (starve_left > 0) begin
                if (BitValid || !ScrambleEn) starve_ok = 0;
                starve_left--;
            end
            if (DataReady) saw_rdy = 1;
            if (BitValid && BitReady) begin
                got_q.push_back(BitOut);
                if (ScrambleEn) scr_cnt++;
                if (SeedLoad) seed_idx = xfers;
                xfers++;
            end
            @(negedge Clock);
        end
        BitReady = 1'b1; DataValid = 1'b1;
        if (!aborted) check("done_seen", done_idx >= 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0; Start = 1'b0; Rate = '0; Length = '0;
        DataByte = '0; DataValid = 1'b0; BitReady = 1'b1;
        #1;
        check("rst_outs", {BitOut, BitValid, DataReady, ScrambleEn, SeedLoad, Busy, Done, Error}, 0);
        check("rst_seed", SeedValue, 7'b1011101);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;

        // Length 1, byte FF
        exp_len1_ff();
        run_frame(4'b1101, 12'd1, 8'hFF, -1, -1, -1);
        cmp("len1");
        check("len1_done_idx", done_idx, 168);
        check("len1_seed_idx", seed_idx, 119);
        check("len1_scr_cnt", scr_cnt, 42);
        check("len1_rdy_seen", saw_rdy, 1);
        Rate = 4'b1101; Start = 1'b1;           // same cycle as Done: must be ignored
        @(negedge Clock);
        Start = 1'b0;
        #1;
        check("start_on_done_busy", Busy, 0);
        check("start_on_done_valid", BitValid, 0);

        // Length 0: SIGNAL parity is 1, 2 pad bits
        exp_q.delete();
        add_preamble();
        add_seq("11010"); add(12, 1'b0); add(1, 1'b1); add(6, 1'b0);
        add(16, 1'b0); add(6, 1'b0); add(2, 1'b0);
        run_frame(4'b1101, 12'd0, 8'h00, -1, -1, -1);
        cmp("len0");
        check("len0_done_idx", done_idx, 144);
        check("len0_rdy_never", saw_rdy, 0);
        check("len0_scr_cnt", scr_cnt, 18);

        // Stall mid-SIGNAL
        exp_len1_ff();
        run_frame(4'b1101, 12'd1, 8'hFF, 100, -1, -1);
        cmp("stall");
        check("stall_hold", stall_ok, 1);
        check("stall_done_idx", done_idx, 168);

        // Invalid rate
        @(negedge Clock);
        Rate = 4'b0000; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        #1;
        check("err_pulse", Error, 1);
        check("err_busy", Busy, 0);
        check("err_valid", BitValid, 0);
        @(negedge Clock);
        #1;
        check("err_one_cycle", Error, 0);

        // Underrun between bytes of a 2-byte PSDU
        exp_q.delete();
        add_preamble();
        add_seq("11010"); add_seq("01"); add(10, 1'b0); add(1, 1'b0); add(6, 1'b0);
        add(16, 1'b0); add_seq("10100101"); add_seq("10100101"); add(6, 1'b0); add(10, 1'b0);
        run_frame(4'b1101, 12'd2, 8'hA5, -1, 144, -1);
        cmp("starve");
        check("starve_gap", starve_ok, 1);
        check("starve_done_idx", done_idx, 168);
        check("starve_scr_cnt", scr_cnt, 42);

        // Reset mid-DATA, then a clean frame
        run_frame(4'b1101, 12'd2, 8'h3C, -1, -1, 140);
        check("pre_rst_busy", Busy, 1);
        Reset = 1'b0;
        #1;
        check("midrst_outs", {BitOut, BitValid, DataReady, ScrambleEn, SeedLoad, Busy, Done, Error}, 0);
        check("midrst_seed", SeedValue, 7'b1011101);
        @(negedge Clock);
        Reset = 1'b1;
        exp_len1_ff();
        run_frame(4'b1101, 12'd1, 8'hFF, -1, -1, -1);
        cmp("after_rst");
        check("after_rst_done_idx", done_idx, 168);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
